// File: rtl/square_pkg.sv
// Shared constants and FSM state type for the fixed-point squarer.
package square_pkg;

  localparam int W_DEF    = 26;
  localparam int FRAC_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fixed_point_square.sv
// Sequential unsigned fixed-point squarer, radix-2 shift-add; done pulses W+1 cycles after the accepting edge.
// start is only accepted when busy=0. Defining FIXED_POINT_SQUARE_ROUND_EN rounds half-up instead of truncating.
module fixed_point_square
  import square_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                start,
  input  logic [W-1:0]        x,
  output logic                busy,
  output logic                done,
  output logic [2*W-FRAC-1:0] y
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = 2*W - FRAC;

  state_t          state;
  logic [W-1:0]    xr;
  logic [2*W-1:0]  acc;
  logic [2*W-1:0]  acc_nxt;
  logic [2*W-1:0]  prod;
  logic [CW-1:0]   cnt;

  // MSB-first: shift the partial product left, add x when the current multiplier bit is set.
  always_comb begin
    acc_nxt = (acc << 1) + ({{W{1'b0}}, xr} & {(2*W){xr[cnt]}});
  end

`ifdef FIXED_POINT_SQUARE_ROUND_EN
  localparam logic [2*W-1:0] HALF = (2*W)'(1) << (FRAC-1);
  // (2^W-1)^2 + 2^(FRAC-1) stays below 2^(2W) because FRAC < W, so no carry out.
  always_comb begin
    prod = acc_nxt + HALF;
  end
`else
  always_comb begin
    prod = acc_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      acc   <= '0;
      cnt   <= '0;
      xr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            acc   <= '0;
            cnt   <= CW'(W-1);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            y     <= YW'(prod >> FRAC);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            acc   <= '0;
            cnt   <= CW'(W-1);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fixed_point_square.md
FIXED_POINT_SQUARE -- requirements
Module: fixed_point_square

Interface
REQ-001 SHALL have parameter W, default 26, meaning operand width in bits (unsigned fixed point).
REQ-002 SHALL have parameter FRAC, default 16, meaning fractional bits of the operand and of the result; legal range 1 <= FRAC < W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_, input, 1 bit: asynchronous, active-high reset (the name is kept; polarity is high).
REQ-005 SHALL have port start, input, 1 bit: request to square x; accepted only when busy=0.
REQ-006 SHALL have port x, input, W bits: unsigned operand, captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1 bit: high while iterating.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking that y is valid.
REQ-009 SHALL have port y, output, 2W-FRAC bits: the result (x*x) >> FRAC.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-011 SHALL move IDLE->RUN on start=1, capturing x, clearing the 2W-bit accumulator and loading the iteration counter with W-1.
REQ-012 SHALL perform, in each RUN cycle, one radix-2 shift-add step of x times x, and decrement the counter.
REQ-013 SHALL move RUN->DONE on the cycle where counter=0, which gives exactly W RUN cycles.
REQ-014 SHALL hold the exact value x*x in the accumulator on entry to DONE, with no overflow across the full operand range.
REQ-015 SHALL load y on the RUN->DONE edge and hold it unchanged until the next RUN->DONE edge.
REQ-016 SHALL assert done only in DONE, so done=1 on cycle W+1 after the accepting edge.
REQ-017 SHALL move DONE->RUN on start=1 (back-to-back operation) and DONE->IDLE otherwise.
REQ-018 SHALL drive busy=1 exactly in RUN.
REQ-019 SHALL ignore start while in RUN and SHALL NOT capture x while in RUN.
REQ-020 SHALL ignore changes on x after capture for the rest of the operation.

Reset
REQ-021 SHALL, while rst_=1, force state to IDLE, busy=0, done=0, y=0, accumulator=0 and counter=0, regardless of clk.
REQ-022 SHALL abort an operation in RUN or DONE when rst_ is asserted; no done pulse follows for that operation.
REQ-023 SHALL accept start on the first rising edge after rst_ deasserts.

Configuration
REQ-024 SHALL compute y = (x*x + 2^(FRAC-1)) >> FRAC, rounding half-up, when macro FIXED_POINT_SQUARE_ROUND_EN is defined.
REQ-025 SHALL compute y = (x*x) >> FRAC, truncating, when FIXED_POINT_SQUARE_ROUND_EN is undefined.
REQ-026 SHALL keep latency, handshake and port widths identical in both builds; the rounded result SHALL NOT overflow y for any x.

Structure
REQ-027 SHALL place the default W and FRAC constants and the state enum typedef (IDLE, RUN, DONE) in the shared package square_pkg.
REQ-028 SHALL be a single module with no sub-module; the shift-add datapath and the FSM are not worth splitting.

Verification
REQ-029 SHALL cover the unity and zero cases (W=26, FRAC=16):
- x=0x10000 (1.0) -> done at cycle 27, y=0x10000.
- x=0 -> y=0.
REQ-030 SHALL cover a non-unity multiply: x=0x30000 (3.0) -> y=0x90000 (9.0).
REQ-031 SHALL cover the rounding boundary:
- x=181 -> y=0 in both builds.
- x=182 -> y=0 truncated, y=1 with FIXED_POINT_SQUARE_ROUND_EN.
REQ-032 SHALL cover the maximum operand: x=0x3FFFFFF -> y=0xFFFFFF800 in both builds.
REQ-033 SHALL cover the handshake cases:
- start pulsed mid-RUN with a different x -> ignored; the first result is unchanged.
- start held during DONE -> the next result's done pulse arrives 27 cycles later.
REQ-034 SHALL cover reset mid-operation: rst_=1 at RUN cycle 10 -> busy=0, done=0 and y=0 immediately; no done pulse; a new start after release completes normally.
